// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_conv_arbiter
//  Description : Round-robin arbiter that shares one binary-to-Gray converter
//                among N_REQ requesters. The converted word and the winning
//                requester ID are held in a one-entry output register that is
//                drained through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] bin_flat,
    output logic [N_REQ-1:0]       gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_gray,
    output logic [ID_W-1:0]        out_id
);

    // Output-register occupancy states
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(N_REQ - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_gray;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_rr_ptr;

    logic             w_any;
    logic [ID_W-1:0]  w_win;
    int               w_idx;
    logic             w_can_accept;
    logic             w_accept;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_gray;
    logic [ID_W-1:0]  w_next_ptr;

    // Round-robin scan: walk offsets from the far end back toward rr_ptr so the
    // last hit recorded is the first requester at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_idx = int'(r_rr_ptr) + off;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (req[w_idx[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[ID_W-1:0];
            end
        end
    end

    // Select the winner's binary word with a constant-indexed mux
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_bin = bin_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    // Bitwise Gray conversion: each bit is the XOR of itself and its upper neighbour
    assign w_gray = w_bin ^ (w_bin >> 1);

    // The register can take a new word when empty or when it is being drained
    assign w_can_accept = (r_state == c_ST_EMPTY) | out_ready;
    assign w_accept     = w_any & w_can_accept & ~rst;
    assign w_next_ptr   = (w_win == c_LAST_ID) ? '0 : w_win + ID_W'(1);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign gnt[gi] = w_accept & (w_win == ID_W'(gi));
        end
    endgenerate

    // Output register FSM with the round-robin pointer advancing on every accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_EMPTY;
            r_gray   <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_gray   <= w_gray;
                r_id     <= w_win;
                r_rr_ptr <= w_next_ptr;
            end
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= c_ST_FULL;
                    end
                end
                c_ST_FULL: begin
                    if (out_ready && !w_accept) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                default: r_state <= c_ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == c_ST_FULL);
    assign out_gray  = r_gray;
    assign out_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_conv_arbiter
//  Description : Directed-vector bench for gray_conv_arbiter with a
//                behavioural reference model and per-cycle output compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int ID_W  = $clog2(N_REQ);

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] bin_flat;
    logic [N_REQ-1:0]       gnt;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_gray;
    logic [ID_W-1:0]        out_id;

    int n_pass  = 0;
    int n_total = 0;

    gray_conv_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bin_flat  (bin_flat),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference Gray conversion written straight from the bit definition
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    // ---------------- behavioural model ----------------
    bit      m_live  = 1'b0;
    bit      m_valid = 1'b0;
    int      m_gray  = 0;
    int      m_id    = 0;
    int      m_ptr   = 0;

    // Winner index under the model's pointer, -1 when nothing can be accepted
    function automatic int model_winner();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        for (int off = 0; off < N_REQ; off++) begin
            int k;
            k = (m_ptr + off) % N_REQ;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int k;
        k = model_winner();
        m_live <= 1'b1;
        if (rst) begin
            m_valid <= 1'b0;
            m_gray  <= 0;
            m_id    <= 0;
            m_ptr   <= 0;
        end else if (k >= 0) begin
            m_valid <= 1'b1;
            m_gray  <= int'(to_gray(bin_flat[k*WIDTH +: WIDTH]));
            m_id    <= k;
            m_ptr   <= (k + 1) % N_REQ;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle compare, mid-cycle
    always @(negedge clk) begin
        if (m_live) begin
            int k;
            logic [N_REQ-1:0] eg;
            k  = model_winner();
            eg = '0;
            if (k >= 0) eg[k] = 1'b1;
            check("model_gnt", 32'(gnt), 32'(eg));
            check("model_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("model_gray", 32'(out_gray), m_gray);
                check("model_id", 32'(out_id), m_id);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bin(input int i, input logic [WIDTH-1:0] v);
        bin_flat[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        logic [N_REQ-1:0] t3_gnt [5];
        logic [WIDTH-1:0] t3_gray[5];
        logic [WIDTH-1:0] t5_in  [3];
        logic [WIDTH-1:0] t5_out [3];
        t3_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t3_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0000};
        t5_in   = '{4'b1111, 4'b0000, 4'b1000};
        t5_out  = '{4'b1000, 4'b0000, 4'b1100};

        rst = 1'b1; req = 4'b1111; bin_flat = '0; out_ready = 1'b1;

        // T1 reset held two cycles
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            check("t1_gnt", 32'(gnt), 0);
            check("t1_valid", 32'(out_valid), 0);
            check("t1_gray", 32'(out_gray), 0);
            check("t1_id", 32'(out_id), 0);
        end

        // T2 single request
        step();
        rst = 1'b0; req = 4'b0010; set_bin(1, 4'b1011);
        @(negedge clk);
        check("t2_gnt", 32'(gnt), 32'b0010);
        step();
        req = 4'b0000;
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 1);
        check("t2_gray", 32'(out_gray), 32'b1110);
        check("t2_id", 32'(out_id), 1);

        // Reset to restart arbitration at requester 0
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // T3 round robin with all requesters active
        for (int i = 0; i < N_REQ; i++) set_bin(i, WIDTH'(i));
        req = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) check("t3_gnt", 32'(gnt), 32'(t3_gnt[c]));
            if (c > 0) begin
                check("t3_gray", 32'(out_gray), 32'(t3_gray[c-1]));
                check("t3_id", 32'(out_id), (c - 1) % N_REQ);
            end
            step();
            if (c == 4) req = 4'b0000;
        end

        // T4 backpressure
        req = 4'b0100; set_bin(2, 4'b0101);
        step();
        out_ready = 1'b0; set_bin(2, 4'b1001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold_gnt", 32'(gnt), 0);
            check("t4_hold_gray", 32'(out_gray), 32'b0111);
            check("t4_hold_id", 32'(out_id), 2);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_gnt", 32'(gnt), 32'b0100);
        step();
        req = 4'b0000;
        @(negedge clk);
        check("t4_new_gray", 32'(out_gray), 32'b1101);

        // T5 boundary values, then full sweep on requester 3
        for (int c = 0; c < 3 + 16; c++) begin
            logic [WIDTH-1:0] v;
            v = (c < 3) ? t5_in[c] : WIDTH'(c - 3);
            step();
            req = 4'b1000; set_bin(3, v);
            @(negedge clk);
            check("t5_gnt", 32'(gnt), 32'b1000);
            step();
            req = 4'b0000;
            @(negedge clk);
            if (c < 3) check("t5_literal", 32'(out_gray), 32'(t5_out[c]));
            else       check("t5_sweep", 32'(out_gray), 32'(v ^ (v >> 1)));
            check("t5_id", 32'(out_id), 3);
        end

        // T6 reset while a result is held
        step();
        req = 4'b1111; out_ready = 1'b0;
        step();
        @(negedge clk);
        check("t6_pre_valid", 32'(out_valid), 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_gnt", 32'(gnt), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_first_gnt", 32'(gnt), 32'b0001);
        step();
        req = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        check("t6_id", 32'(out_id), 0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
